// File: rtl/irq_request_gen_pkg.sv
// ---------------------------------------------------------------------------
// irq_request_gen_pkg
// Shared definitions for the interrupt request generator:
//   NCH          number of interrupt channels
//   CH0..CH2     channel index constants (CH2 has highest downstream priority)
//   irq_state_e  per-channel request state (IDLE / REQ)
// ---------------------------------------------------------------------------
package irq_request_gen_pkg;

   localparam int NCH = 3;

   localparam int CH0 = 0;
   localparam int CH1 = 1;
   localparam int CH2 = 2;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } irq_state_e;

endpackage : irq_request_gen_pkg

// File: rtl/irq_debounce.sv
// ---------------------------------------------------------------------------
// irq_debounce
// One channel's front end: a two-flop synchronizer, a debounce counter and a
// rising-edge event on the debounced level.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   btn_i   raw asynchronous, bouncing input
//   lvl_o   debounced level
//   rise_o  one-cycle pulse in the cycle after lvl_o goes 0->1
// ---------------------------------------------------------------------------
module irq_debounce
   import irq_request_gen_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic lvl_o,
   output logic rise_o
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             lvl_q;
   logic             lvl_d;
   logic             lvl_prev_q;

   // The counter only runs while the synchronized input disagrees with the
   // debounced level. Reaching CNT_MAX with the disagreement still present
   // means DB_CYCLES consecutive differing samples: accept the new level and
   // restart from zero, so the counter never wraps.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q != lvl_q) begin
         if (cnt_q == CNT_MAX) begin
            lvl_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         cnt_q      <= '0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         cnt_q      <= cnt_d;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
      end
   end

   assign lvl_o  = lvl_q;
   // Combinational from two flops: high for exactly the cycle after a rise,
   // so the request FSM registers it on the very next edge.
   assign rise_o = lvl_q & ~lvl_prev_q;

endmodule : irq_debounce

// File: rtl/irq_request_gen.sv
// ---------------------------------------------------------------------------
// irq_request_gen
// Turns bouncing interrupt sources into held break requests with per-channel
// enable, acknowledge and sticky overrun reporting.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   btn      raw interrupt sources, bit n = channel n
//   en       per-channel request enable (0 = masked)
//   ack      one-cycle acknowledge pulse per channel
//   clr_ovr  one-cycle pulse clearing all overrun flags
//   brk      request level, held until acknowledged (registered)
//   ovr      sticky overrun flag per channel
//   db_lvl   debounced level per channel
// ---------------------------------------------------------------------------
module irq_request_gen
   import irq_request_gen_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] btn,
   input  logic [NCH-1:0] en,
   input  logic [NCH-1:0] ack,
   input  logic           clr_ovr,
   output logic [NCH-1:0] brk,
   output logic [NCH-1:0] ovr,
   output logic [NCH-1:0] db_lvl
);

   logic [NCH-1:0] rise;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         irq_state_e state_q;
         irq_state_e state_d;
         logic       brk_q;
         logic       brk_d;
         logic       ovr_q;
         logic       ovr_d;
         logic       ovr_set;
         logic       ev;

         irq_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn[gi]),
            .lvl_o  (db_lvl[gi]),
            .rise_o (rise[gi])
         );

         // Masked events are dropped here, so they can neither raise a
         // request nor flag an overrun.
         assign ev = rise[gi] & en[gi];

         always_comb begin
            state_d = state_q;
            ovr_set = 1'b0;
            case (state_q)
               IDLE: begin
                  // ack while idle has nothing to acknowledge
                  if (ev) begin
                     state_d = REQ;
                  end
               end
               REQ: begin
                  if (ev) begin
                     // With ack in the same cycle the new event simply
                     // replaces the acknowledged request; without it the
                     // previous request is still pending.
                     if (!ack[gi]) begin
                        ovr_set = 1'b1;
                     end
                  end else if (ack[gi]) begin
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
            // set has priority over a simultaneous clear
            ovr_d = ovr_set | (ovr_q & ~clr_ovr);
            // brk is its own flop so the output never glitches
            brk_d = (state_d == REQ);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q <= IDLE;
               brk_q   <= 1'b0;
               ovr_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               brk_q   <= brk_d;
               ovr_q   <= ovr_d;
            end
         end

         assign brk[gi] = brk_q;
         assign ovr[gi] = ovr_q;
      end
   endgenerate

endmodule : irq_request_gen

// File: tb/tb_irq_request_gen.sv
// ---------------------------------------------------------------------------
// tb_irq_request_gen
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a behavioural model of the request generator.
// ---------------------------------------------------------------------------
module tb_irq_request_gen;

   localparam int DB = 4;
   localparam int N  = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn;
   logic [N-1:0] en;
   logic [N-1:0] ack;
   logic         clr_ovr;
   logic [N-1:0] brk;
   logic [N-1:0] ovr;
   logic [N-1:0] db_lvl;

   int n_cmp = 0;
   int n_err = 0;

   irq_request_gen #(
      .DB_CYCLES (DB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .en      (en),
      .ack     (ack),
      .clr_ovr (clr_ovr),
      .brk     (brk),
      .ovr     (ovr),
      .db_lvl  (db_lvl)
   );

   always #5 clk = ~clk;

   // Behavioural model: raw input seen two edges late, a run length of
   // consecutive samples disagreeing with the debounced level, a "rose"
   // marker for the event cycle, and a pending-request flag per channel.
   bit m_d1   [N];
   bit m_d2   [N];
   bit m_db   [N];
   bit m_rose [N];
   bit m_pend [N];
   bit m_ovr  [N];
   int m_run  [N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_d1[i] = 0; m_d2[i] = 0; m_db[i] = 0; m_rose[i] = 0;
         m_pend[i] = 0; m_ovr[i] = 0; m_run[i] = 0;
      end
   endtask

   // Called right after a rising edge, using the inputs present at that edge.
   task automatic model_step();
      for (int i = 0; i < N; i++) begin
         bit ev;
         bit set;
         ev  = m_rose[i] && en[i];
         set = 0;
         if (m_pend[i]) begin
            if (ev) set = !ack[i];
            else if (ack[i]) m_pend[i] = 0;
         end else if (ev) begin
            m_pend[i] = 1;
         end
         if (set) m_ovr[i] = 1;
         else if (clr_ovr) m_ovr[i] = 0;

         m_rose[i] = 0;
         if (m_d2[i] != m_db[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == DB) begin
            m_db[i]   = !m_db[i];
            m_rose[i] = m_db[i];
            m_run[i]  = 0;
         end
         m_d2[i] = m_d1[i];
         m_d1[i] = btn[i];
      end
   endtask

   task automatic check_vec(input string tag, input logic [N-1:0] got,
                            input logic [N-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] e_brk;
      logic [N-1:0] e_ovr;
      logic [N-1:0] e_db;
      for (int i = 0; i < N; i++) begin
         e_brk[i] = m_pend[i];
         e_ovr[i] = m_ovr[i];
         e_db[i]  = m_db[i];
      end
      check_vec({tag, ".brk"}, brk, e_brk);
      check_vec({tag, ".ovr"}, ovr, e_ovr);
      check_vec({tag, ".db_lvl"}, db_lvl, e_db);
   endtask

   task automatic tick(input string tag = "cyc");
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag = "cyc");
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   // Counts edges until all bits in mask are high on brk; bounded.
   task automatic wait_brk(input logic [N-1:0] mask, input int exp_edges,
                           input string tag);
      int cnt;
      cnt = 0;
      while (((brk & mask) !== mask) && (cnt < 40)) begin
         tick(tag);
         cnt++;
      end
      n_cmp++;
      assert (cnt == exp_edges) else begin
         n_err++;
         $error("FAIL %s latency observed=%0d expected=%0d", tag, cnt, exp_edges);
      end
   endtask

   task automatic pulse_ack(input logic [N-1:0] a, input string tag);
      ack = a;
      tick(tag);
      ack = '0;
   endtask

   initial begin
      int guard;
      rst = 1'b1; btn = '0; en = '0; ack = '0; clr_ovr = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ticks(3, "post_reset");
      $display("step: reset released");

      // single channel latency and acknowledge
      en = 3'b001;
      btn = 3'b001;
      wait_brk(3'b001, DB + 3, "ch0_latency");
      pulse_ack(3'b001, "ch0_ack");
      check_vec("ch0_ack_fall", brk & 3'b001, 3'b000);
      btn = '0;
      ticks(8, "ch0_release");
      $display("step: ch0 request and ack, brk=%b ovr=%b", brk, ovr);

      // short glitches never reach the debounced level
      en = 3'b111;
      for (int r = 0; r < 5; r++) begin
         btn[1] = 1'b1; ticks(3, "ch1_glitch_hi");
         btn[1] = 1'b0; ticks(3, "ch1_glitch_lo");
      end
      check_vec("ch1_glitch_db", db_lvl & 3'b010, 3'b000);
      check_vec("ch1_glitch_brk", brk & 3'b010, 3'b000);
      $display("step: ch1 glitch train, db_lvl=%b brk=%b", db_lvl, brk);

      // overrun on channel 2, then clear
      btn[2] = 1'b1;
      wait_brk(3'b100, DB + 3, "ch2_latency");
      btn[2] = 1'b0; ticks(6, "ch2_release");
      btn[2] = 1'b1; ticks(6, "ch2_repress");
      ticks(3, "ch2_settle");
      check_vec("ch2_ovr_set", ovr & 3'b100, 3'b100);
      check_vec("ch2_brk_held", brk & 3'b100, 3'b100);
      clr_ovr = 1'b1; tick("ch2_clr");
      clr_ovr = 1'b0;
      check_vec("ch2_ovr_clr", ovr & 3'b100, 3'b000);
      pulse_ack(3'b100, "ch2_ack");
      btn[2] = 1'b0;
      ticks(8, "ch2_idle");
      $display("step: ch2 overrun and clear, ovr=%b brk=%b", ovr, brk);

      // new event coincident with ack replaces the request
      btn[0] = 1'b1;
      wait_brk(3'b001, DB + 3, "ch0b_latency");
      btn[0] = 1'b0; ticks(8, "ch0b_release");
      btn[0] = 1'b1;
      guard = 0;
      do begin
         tick("ch0b_wait_rise");
         guard++;
      end while (!m_rose[0] && guard < 20);
      n_cmp++;
      assert (guard == DB + 2) else begin
         n_err++;
         $error("FAIL ch0b_rise_time observed=%0d expected=%0d", guard, DB + 2);
      end
      pulse_ack(3'b001, "ch0b_coincident");
      check_vec("ch0b_brk_kept", brk & 3'b001, 3'b001);
      check_vec("ch0b_no_ovr", ovr & 3'b001, 3'b000);
      ticks(3, "ch0b_hold");
      pulse_ack(3'b001, "ch0b_final_ack");
      check_vec("ch0b_brk_fall", brk & 3'b001, 3'b000);
      btn[0] = 1'b0;
      ticks(8, "ch0b_idle");
      $display("step: ch0 event with coincident ack, brk=%b ovr=%b", brk, ovr);

      // masked presses are discarded; enabling later needs a fresh press
      en = 3'b000;
      btn = 3'b111;
      ticks(12, "masked_press");
      check_vec("masked_brk", brk, 3'b000);
      en = 3'b111;
      ticks(12, "enabled_held");
      check_vec("enabled_held_brk", brk, 3'b000);
      btn = 3'b000; ticks(8, "all_release");
      btn = 3'b111;
      wait_brk(3'b111, DB + 3, "all_latency");
      $display("step: mask then re-press, brk=%b", brk);

      // reset mid-request with sources held
      rst = 1'b1;
      model_reset();
      #1;
      check_all("rst_mid");
      check_vec("rst_mid_brk", brk, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_brk(3'b111, DB + 3, "post_rst_latency");
      pulse_ack(3'b111, "post_rst_ack");
      btn = '0;
      ticks(8, "post_rst_idle");
      $display("step: reset mid-request, brk=%b ovr=%b", brk, ovr);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
            ack[i] = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 39) == 0) en = N'($urandom_range(0, 7));
         clr_ovr = ($urandom_range(0, 19) == 0);
         tick("random");
      end
      ack = '0; clr_ovr = 1'b0;
      $display("step: random phase done, brk=%b ovr=%b db_lvl=%b", brk, ovr, db_lvl);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_irq_request_gen

// File: doc/irq_request_gen.md
IRQ_REQUEST_GEN -- requirements
Module: irq_request_gen

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable cycles required before a debounced level changes; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn  input  3  raw, asynchronous, bouncing interrupt sources; bit n = channel n, channel 2 highest priority downstream.
REQ-005 en  input  3  per-channel request enable; 0 = channel masked.
REQ-006 ack  input  3  one-cycle pulse from the interrupt controller; bit n = request n latched.
REQ-007 clr_ovr  input  1  one-cycle pulse; clears all overrun flags.
REQ-008 brk  output  3  request level to the controller break inputs; held high until acknowledged.
REQ-009 ovr  output  3  sticky overrun flag per channel.
REQ-010 db_lvl  output  3  debounced level per channel, for status and debug.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per channel, a counter SHALL increment while the synchronized input differs from db_lvl and SHALL clear when they are equal.
REQ-013 When the counter reaches DB_CYCLES-1 while the inputs still differ, db_lvl SHALL toggle and the counter SHALL clear.
REQ-014 A 0->1 transition of db_lvl SHALL produce a one-cycle internal event in the cycle after the toggle.
REQ-015 A 1->0 transition of db_lvl SHALL produce no event.
REQ-016 Per-channel FSM states:
- IDLE: brk=0. An event with en=1 moves to REQ.
- REQ: brk=1. ack=1 moves to IDLE.
REQ-017 Events with en=0 SHALL be discarded, with no brk and no ovr.
REQ-018 Clearing en while in REQ SHALL NOT withdraw brk.
REQ-019 An event in REQ without ack SHALL set ovr[n] and leave the state at REQ.
REQ-020 Event and ack in the same cycle while in REQ: the state SHALL stay REQ, brk SHALL stay 1, and ovr SHALL NOT be set (the new request replaces the acknowledged one).
REQ-021 ack in IDLE SHALL be ignored.
REQ-022 clr_ovr and an overrun-setting event in the same cycle: set SHALL win.
REQ-023 Latency: brk SHALL rise exactly DB_CYCLES+3 rising edges after the first edge at which btn is sampled high-and-stable (2 synchronizer + DB_CYCLES debounce + 1 event/FSM).
REQ-024 brk SHALL fall on the edge after ack is sampled.
REQ-025 Glitches shorter than DB_CYCLES cycles SHALL never change db_lvl.
REQ-026 The counter SHALL be width clog2(DB_CYCLES) and SHALL never wrap.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL all assert brk in the same cycle.
REQ-028 brk SHALL be glitch-free and SHALL be driven directly from a flop.

Reset
REQ-029 rst SHALL asynchronously force all of the following to 0: synchronizers, counters, db_lvl, FSMs (IDLE), brk, ovr.
REQ-030 Reset mid-request SHALL drop brk immediately with no pending memory.
REQ-031 A source held high through reset deassertion SHALL produce a request after DB_CYCLES+3 cycles, because db_lvl restarts at 0.
REQ-032 Reset deassertion SHALL be synchronized externally; the block SHALL NOT require clk during rst.

Structure
REQ-033 A shared package SHALL hold: NCH=3, the FSM state typedef (IDLE, REQ), and the channel index constants.
REQ-034 One sub-module, irq_debounce, SHALL implement one channel's synchronizer, debounce counter and rise-event; it SHALL be instantiated NCH times.
REQ-035 The FSM and overrun logic SHALL live in the top module.

Verification
REQ-036 DB_CYCLES=4, en=3'b001, btn[0] stepped 0->1 and held -> brk[0] rises at edge 7; ack[0] pulse -> brk[0] low next edge; ovr=0.
REQ-037 DB_CYCLES=4, btn[1] pulses high for 3 cycles at a time, repeated -> db_lvl[1] stays 0 and brk[1] never rises.
REQ-038 btn[2] request pending, then btn[2] released and re-pressed (each level held 6 cycles) with no ack -> ovr[2]=1 and brk[2] stays 1; clr_ovr -> ovr[2]=0.
REQ-039 Second event coincident with ack[0] -> brk[0] stays 1 continuously and ovr[0]=0; a further ack -> brk[0]=0.
REQ-040 en=3'b000, press all channels -> brk=0; then en=3'b111 with buttons still held -> no request until release followed by re-press.
REQ-041 rst asserted while brk=3'b111 -> brk=0 and ovr=0 immediately; btn still held after rst release -> brk=3'b111 after DB_CYCLES+3 edges.
